// File: rtl/alu_arbiter_if.sv
// Requester and response channels of alu_arbiter, grouped as one bus.
// The master side is the requesters/consumer, the slave side is the arbiter.
interface alu_arbiter_if #(parameter int NREQ = 2);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][5:0]   req_op;
   logic [NREQ-1:0][31:0]  req_src1;
   logic [NREQ-1:0][31:0]  req_src2;
   logic [NREQ-1:0][31:0]  req_imm;
   logic [NREQ-1:0][3:0]   req_shamt;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_id;
   logic [31:0]            rsp_data;

   modport master (
      output req_valid, req_op, req_src1, req_src2, req_imm, req_shamt, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, req_imm, req_shamt, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module alu_arbiter #(
   parameter int NREQ = 2
) (
   input  logic               clk,
   input  logic               rst,
   alu_arbiter_if.slave       bus,
   output logic [5:0]         alu_cntrl,
   output logic [31:0]        alu_src1,
   output logic [31:0]        alu_src2,
   output logic [31:0]        alu_imm,
   output logic [3:0]         alu_shamt,
   input  logic [31:0]        alu_result,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic              gnt;
   logic              any_valid;
   logic              handshake;
   logic [NREQ-1:0]   ready_d;
   logic [5:0]        op_q;
   logic [31:0]       src1_q, src2_q, imm_q;
   logic [3:0]        shamt_q;
   logic              id_q;
   logic [31:0]       rsp_data_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic              last_gnt_q;
`endif

   // Grant selection; on contention either port 0 always wins or the port not served last wins.
   always_comb begin
      gnt       = 1'b0;
      any_valid = |bus.req_valid;
      case (bus.req_valid)
         2'b01:   gnt = 1'b0;
         2'b10:   gnt = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         2'b11:   gnt = 1'b0;
`else
         2'b11:   gnt = ~last_gnt_q;
`endif
         default: gnt = 1'b0;
      endcase
   end

   // Accept only from IDLE, and never in a reset cycle.
   always_comb begin
      handshake = (state_q == IDLE) && !rst && any_valid;
      ready_d   = '0;
      if (handshake) ready_d[gnt] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (handshake) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         imm_q      <= '0;
         shamt_q    <= '0;
         id_q       <= 1'b0;
         rsp_data_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_gnt_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         if (handshake) begin
            op_q       <= bus.req_op[gnt];
            src1_q     <= bus.req_src1[gnt];
            src2_q     <= bus.req_src2[gnt];
            imm_q      <= bus.req_imm[gnt];
            shamt_q    <= bus.req_shamt[gnt];
            id_q       <= gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_gnt_q <= gnt;
`endif
         end
         if (state_q == EXEC) rsp_data_q <= alu_result;
      end
   end

   assign bus.req_ready = ready_d;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = (state_q != IDLE);

   assign alu_cntrl = op_q;
   assign alu_src1  = src1_q;
   assign alu_src2  = src2_q;
   assign alu_imm   = imm_q;
   assign alu_shamt = shamt_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters: port 0 (core execute stage) and port 1 (debug/DMA helper). It arbitrates with valid/ready handshakes, registers the granted operands, drives the ALU for one cycle, and captures the result. The result is returned on a shared response channel tagged with the requester ID and held under backpressure. It sits between the issue logic and the ALU instance; nothing else drives the ALU inputs.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (fixed at 2; the ID is 1 bit).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[i]`  in  1  requester i (i = 0, 1) presents an operation.
- `req_ready[i]`  out  1  arbiter accepts requester i's operation this cycle.
- `req_op[i]`  in  6  ALU control code, the same encoding as `alu_cntrl`.
- `req_src1[i]`, `req_src2[i]`, `req_imm[i]`  in  32 each  operands.
- `req_shamt[i]`  in  4  shift amount.
- `alu_cntrl`  out  6  drives the ALU.
- `alu_src1`, `alu_src2`, `alu_imm`  out  32 each  drive the ALU.
- `alu_shamt`  out  4  drives the ALU.
- `alu_result`  in  32  ALU output, combinational from the `alu_*` outputs.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_data`  out  32  captured ALU result.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: if exactly one `req_valid` is high, that requester wins.
  - If both are high, the requester not equal to `last_gnt` wins (round-robin).
  - `req_ready[g]=1` only for the winner and only in IDLE. The other `req_ready` is 0.
  - On handshake: latch op, src1, src2, imm, shamt and the ID into the operand registers, set `last_gnt=g`, and go to EXEC.
- EXEC:
  - `alu_*` are driven from the operand registers.
  - `alu_result` is captured into `rsp_data`.
  - Go to RESP.
- RESP:
  - `rsp_valid=1`; `rsp_data` and `rsp_id` are stable.
  - On `rsp_valid & rsp_ready`, go to IDLE. Otherwise hold indefinitely.
- Outside EXEC, `alu_*` still show the operand registers, and their values are don't-care for consumers.
- Requests are never dropped. A requester must hold `req_valid` and its operands stable until `req_ready`.
- Undefined op codes pass through unchanged. The ALU returns 0 for them and the arbiter does not flag them.

## Timing
- Reset values:
  - State IDLE, `last_gnt=1` (port 0 wins the first contention).
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `busy=0`.
  - Operand registers 0, so `alu_cntrl=0` and all `alu_*` are 0.
- Latency: handshake at edge N → `rsp_valid=1` after edge N+2.
- Throughput: at most one op per 3 cycles with `rsp_ready` tied high. The next `req_ready` can be asserted in the cycle after the response handshake.
- Simultaneous valid on both ports:
  - Winner per round-robin.
  - Loser stalls, then wins the next IDLE arbitration if it is still valid.
  - Loser waits at most one op, so no starvation.
- `req_valid` that arrives during EXEC or RESP: `req_ready` stays 0 and nothing is latched.
- Backpressure: while `rsp_ready=0`, `rsp_data`, `rsp_id` and `rsp_valid` must not change.
- `rst` asserted in any state: in-flight op is discarded, the FSM returns to IDLE on the next edge, and no response is issued.
- `rst` in the same cycle as a request: no handshake (`req_ready=0` while `rst=1`).

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 0 always wins contention, and `last_gnt` is not used for arbitration (it may be left unimplemented). Port 1 can starve by design.
  - Undefined (default): round-robin as above.

## Test plan
- Single op: port 0 sends op 6'b000000 (ADD), src1=5, src2=7 with `rsp_ready=1` → `rsp_valid` 2 cycles after the handshake, `rsp_data`=12, `rsp_id`=0, `busy` high for 2 cycles.
- Contention from reset:
  - Setup: both ports valid; port 0 sends SUB 10−3, port 1 sends XOR 0xF0^0x0F.
  - Expect: port 0 is served first (`rsp_data`=7, `rsp_id`=0).
  - Then port 1 (`rsp_data`=0xFF, `rsp_id`=1).
  - Then, with both still valid, port 0 wins again.
- Backpressure: hold `rsp_ready=0` for 5 cycles after `rsp_valid` on SLT(−1, 1) → `rsp_data`=1 held stable, both `req_ready`=0 throughout, IDLE one cycle after `rsp_ready` rises.
- Reset mid-op: assert `rst` for one cycle during EXEC of an ADDI → no `rsp_valid` appears, all outputs return to their reset values, and the next request completes normally.
- Macro: with `ALU_ARB_FIXED_PRIO_EN` defined and both ports valid for 4 consecutive ops → all 4 responses have `rsp_id`=0. Without the macro, the IDs alternate 0, 1, 0, 1.
